bitwise_multicycle: RTL
=======================

Name: bitwise_multicycle

Overview:
- Parametrised, multi-cycle bitwise logic unit for the processor datapath. It generalises the fixed 32-bit OR to any WIDTH and to four operations.
- Processes operands SLICE bits per cycle, which bounds the combinational width per cycle.
- Uses the same start / result-ready handshake as the multiply/divide unit, so the execute stage can stall on it uniformly.
- Also reports whether the result is non-zero.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. Must divide WIDTH exactly. N = WIDTH/SLICE slice steps.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  start request, sampled on every rising edge.
- ctrl_op  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- operandA  in  WIDTH  first operand.
- operandB  in  WIDTH  second operand.
- result  out  WIDTH  registered result of the last completed operation.
- result_nonzero  out  1  registered OR-reduction of result.
- busy  out  1  high while an operation is in progress (RUN state).
- data_resultRDY  out  1  one-cycle pulse when result and result_nonzero are newly valid.

Behaviour:
- Reset: on a rising edge with reset=1:
  - state goes to IDLE and the slice counter to 0;
  - result, result_nonzero, busy and data_resultRDY go to 0;
  - shadow registers are cleared.
  - Reset overrides ctrl_start on the same edge, and an operation in progress is aborted with no RDY pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - ctrl_start=1 latches operandA, operandB, ctrl_op and an empty shadow accumulator, clears the counter, and moves to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle writes op(A_lat[k*SLICE +: SLICE], B_lat[k*SLICE +: SLICE]) into shadow[k*SLICE +: SLICE], with k = counter.
  - When k = N-1, moves to DONE, loads result <= complete shadow and result_nonzero <= |shadow. Otherwise counter increments.
  - ctrl_start is ignored; no restart or abort.
- DONE:
  - data_resultRDY=1 and busy=0.
  - ctrl_start=1 is accepted exactly as in IDLE (next state RUN); otherwise the next state is IDLE.
- Latency: start sampled high in cycle 0 gives RDY high in cycle N+1 (cycle 5 for 32/8; cycle 2 when SLICE=WIDTH).
- Peak throughput: one operation per N+1 cycles.
- Operand isolation: operands and ctrl_op are latched at acceptance. Input changes afterwards have no effect on the operation.
- Result stability:
  - result and result_nonzero change only on the edge entering DONE, updating atomically.
  - Partial slices are never visible on the outputs.
  - Values hold through IDLE and through any following RUN until that operation's DONE.
- data_resultRDY is never high for two consecutive cycles.
- Exactly one RDY pulse per accepted start, except for starts aborted by reset.
- NOR is the complement of OR per slice. No arithmetic, carries or exceptions.
- Elaboration: WIDTH % SLICE != 0 or SLICE = 0 is a fatal elaboration error. Counter width is clog2(N), minimum 1.

Decomposition:
- Shared package bitwise_pkg holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - state encodings S_IDLE, S_RUN, S_DONE.
- One natural sub-module, bitwise_slice, parametrised by SLICE. It is purely combinational: inputs a, b, op; output y.
- The top holds the FSM, counter, latches, shadow and output registers.

Test Plan:
- OR (default params): A=32'hF0F0_0000, B=32'h0F0F_00FF, op=01, start in cycle 0 -> result=32'hFFFF_00FF, result_nonzero=1, RDY high only in cycle 5, busy high in cycles 1-4.
- NOR and AND zero case: A=B=0, op=11 -> result=32'hFFFF_FFFF, nonzero=1. Then A=32'hAAAA_AAAA, B=32'h5555_5555, op=00 -> result=0, nonzero=0.
- Isolation and ignored start: XOR with A=32'hAAAA_AAAA, B=32'hFFFF_FFFF. In cycle 2, drive A=0, B=0, op=00 and pulse start -> result=32'h5555_5555, exactly one RDY pulse, in cycle 5.
- Reset mid-operation: start OR, assert reset in cycle 3 -> cycle 4 shows all outputs 0 and state IDLE, with no RDY. A fresh XOR of 32'h0000_FFFF with 32'h00FF_00FF completes with 32'h00FF_FF00.
- Back-to-back: start held high in the DONE cycle of op 1 (OR result 32'h1) with op 2 = AND of 32'h3 and 32'h2 -> result stays 32'h1 until op 2's DONE, then 32'h2. Two separated single-cycle RDY pulses.
- SLICE=32, WIDTH=32: OR of 32'h8000_0000 and 32'h1 -> 32'h8000_0001 with RDY in cycle 2. WIDTH=16, SLICE=4: latency 5 cycles.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared encodings for the multi-cycle bitwise logic unit.
package bitwise_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Slice counter width; a single-step configuration still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitwise_slice.sv
// Combinational bitwise operation on one SLICE-bit chunk of the operands.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_e              op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/bitwise_multicycle.sv
// Multi-cycle bitwise unit: SLICE bits per cycle with a start / result-ready handshake
// matching the multiply/divide unit.
module bitwise_multicycle
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic             result_nonzero,
    output logic             busy,
    output logic             data_resultRDY
);

    localparam int unsigned N    = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    if ((SLICE == 0) || (((SLICE == 0) ? 0 : (WIDTH % SLICE)) != 0)) begin : g_bad_params
        $fatal(1, "bitwise_multicycle: SLICE must be non-zero and divide WIDTH");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    op_e               op_q, op_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              nz_q, nz_d;

    logic [31:0]       base;
    logic [SLICE-1:0]  a_sl, b_sl, y_sl;

    assign base = 32'(cnt_q) * SLICE;
    assign a_sl = a_q[base +: SLICE];
    assign b_sl = b_q[base +: SLICE];

    bitwise_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q),
        .y  (y_sl)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        shadow_d = shadow_q;
        result_d = result_q;
        nz_d     = nz_q;

        if (state_q == S_RUN) begin
            // Start is ignored while running; the operation always completes.
            shadow_d[base +: SLICE] = y_sl;
            if (cnt_q == CntLast) begin
                state_d  = S_DONE;
                result_d = shadow_d;
                nz_d     = |shadow_d;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            // IDLE and DONE accept a start identically.
            state_d = S_IDLE;
            if (ctrl_start) begin
                state_d  = S_RUN;
                cnt_d    = '0;
                a_d      = operandA;
                b_d      = operandB;
                op_d     = op_e'(ctrl_op);
                shadow_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            shadow_q <= '0;
            result_q <= '0;
            nz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            nz_q     <= nz_d;
        end
    end

    assign result         = result_q;
    assign result_nonzero = nz_q;
    assign busy           = (state_q == S_RUN);
    assign data_resultRDY = (state_q == S_DONE);

endmodule
